des_engine_arbiter: RTL and testbench
=====================================

# des_engine_arbiter

Round-robin arbiter and sequencer that shares one `des_encryption_unroll4` engine between `NUM_REQ` requesters. It accepts one {message, round-key set} job at a time from a valid/ready requester port and issues a single-cycle start to the engine. It then waits for the engine's done pulse, registers the ciphertext, and returns it on a valid/ready response port tagged with the requester index. It sits between the requester-side subsystem and the engine instance.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `ID_W`, 2: response tag width, equal to $clog2(NUM_REQ).
- `TIMEOUT`, 63: maximum BUSY cycles before abort. Used only with `DES_ARB_TIMEOUT_EN`.

Ports. Reset is synchronous, active-high.
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `req_valid`  in  NUM_REQ  per-requester job valid.
- `req_ready`  out  NUM_REQ  per-requester accept; one-hot or zero.
- `req_message`  in  64*NUM_REQ  plaintext; requester i uses slice i.
- `req_keys`  in  768*NUM_REQ  16×48-bit round keys; requester i uses slice i.
- `rsp_valid`  out  1  ciphertext available.
- `rsp_ready`  in  1  response consumer accept.
- `rsp_data`  out  64  ciphertext.
- `rsp_id`  out  ID_W  index of the requester that owns `rsp_data`.
- `rsp_err`  out  1  job aborted by timeout; `rsp_data` is 0.
- `eng_start`  out  1  engine start pulse.
- `eng_message`  out  64  engine message input.
- `eng_round_keys`  out  768  engine round-key input.
- `eng_done`  in  1  engine done pulse.
- `eng_result`  in  64  engine result; valid only while `eng_done`=1.

## Operation
- **States:** IDLE, LAUNCH, BUSY, RESP.
- **IDLE:**
  - Grant g is the first index i with `req_valid[i]`=1, searching from `rr_ptr` upward and wrapping modulo NUM_REQ.
  - `req_ready[g]`=1 combinationally. The transfer occurs when valid and ready are both high.
  - On transfer: latch message/keys slice g and the id, set `rr_ptr` ← (g+1) mod NUM_REQ, go to LAUNCH.
  - No valid request: remain in IDLE.
- **LAUNCH:**
  - `eng_start`=1 for exactly one cycle, then go to BUSY.
  - `eng_message`/`eng_round_keys` are driven from the latched registers in every state and stay stable until the next accept.
- **BUSY:** on `eng_done`=1, register `eng_result` into `rsp_data`, clear `rsp_err`, go to RESP.
- **RESP:**
  - `rsp_valid`=1.
  - `rsp_data`/`rsp_id`/`rsp_err` are held stable until `rsp_valid`&&`rsp_ready`, then go to IDLE.
  - `req_ready` is 0 in every state except IDLE.
- **Requester rules:** a requester holds `req_valid` and its data stable until accepted. Deasserting valid before acceptance withdraws the request; no error results.
- **Stray `eng_done`:** ignored in IDLE, LAUNCH and RESP.
- **Reset:**
  - Asserted in any state, including mid-BUSY: state becomes IDLE, `rr_ptr`=0, and the job is dropped without a response.
  - Engine reset (`rst_n`=~`rst`) is wired at integration.
- **Simultaneous events:** a new request arriving during LAUNCH/BUSY/RESP waits; arbitration is evaluated only in IDLE.

## Timing
- **Reset values:** `req_ready`=0, `rsp_valid`=0, `rsp_data`=0, `rsp_id`=0, `rsp_err`=0, `eng_start`=0, `eng_message`=0, `eng_round_keys`=0; state IDLE; `rr_ptr`=0.
- **Job sequence:** accept at cycle T (IDLE) → `eng_start` high at T+1 → BUSY from T+2 → `eng_done` at cycle D → `rsp_valid` high from D+1.
- **Return to IDLE:** if `rsp_ready`=1 at D+1, the block is in IDLE at D+2 and can accept again at D+2.
- **Latency:** the block is agnostic to engine latency; there is no fixed cycle count between start and done.
- **Throughput:** at most one job in flight.

## Configuration
- **`DES_ARB_TIMEOUT_EN` defined:**
  - A 6-bit counter clears on entry to BUSY and increments each BUSY cycle.
  - If it reaches TIMEOUT without `eng_done`, go to RESP with `rsp_err`=1 and `rsp_data`=0.
  - An `eng_done` that arrives in the same cycle the counter reaches TIMEOUT takes priority: normal response, `rsp_err`=0.
- **Not defined:** no counter is built, `rsp_err` is tied to 0, and BUSY waits indefinitely.

## Test plan
- Requester 2 only: message 0x0123456789ABCDEF with round keys from key 0x133457799BBCDFF1, real engine → `rsp_data`=0x85E813540F0AB405, `rsp_id`=2, `rsp_err`=0, `rr_ptr`=3.
- All four `req_valid` held high after reset → responses in id order 0,1,2,3,0. Exactly one `req_ready` bit is high, and only in IDLE.
- `rsp_ready` held low 10 cycles after `rsp_valid` rises → `rsp_valid`, `rsp_data` and `rsp_id` are stable throughout, no `req_ready` is asserted, and IDLE is reached the cycle after `rsp_ready` goes high.
- `rr_ptr`=1 with only `req_valid[3]` high → grant 3 and `rr_ptr` becomes 0. A stray `eng_done` pulse in IDLE → no response.
- `rst` asserted for one cycle mid-BUSY → all outputs return to their reset values the next cycle, no response is produced for the dropped job, and the next request is accepted normally.
- Stub engine that never asserts done:
  - With `DES_ARB_TIMEOUT_EN`: `rsp_valid`=1, `rsp_err`=1, `rsp_data`=0 one cycle after 63 BUSY cycles.
  - Without the macro: `rsp_valid` stays 0 for 1000 cycles.

Source files
------------

// File: rtl/des_engine_arbiter.sv
// des_engine_arbiter
//   Shares one DES engine between NUM_REQ requesters. A round-robin pointer
//   selects one job {message, 16 round keys} in IDLE, the block pulses the
//   engine start, waits for the engine done pulse, and returns the
//   registered ciphertext on the response port tagged with the requester id.
//
//   Handshake semantics (both ports): a transfer happens on a rising clock
//   edge where valid and ready are both 1. A source holds valid and its
//   payload stable until the transfer. Dropping valid before the transfer
//   withdraws the request. The response port holds rsp_valid and its payload
//   stable until rsp_ready is seen.
//
//   Optional feature macro: DES_ARB_TIMEOUT_EN
//     defined   : a 6-bit BUSY watchdog aborts a job after TIMEOUT cycles
//                 (rsp_err=1, rsp_data=0). An eng_done in the expiry cycle wins.
//     undefined : no watchdog, rsp_err is constant 0, BUSY waits for eng_done.
//
//   dbg_state / dbg_rr_ptr expose the FSM state and round-robin pointer.
module des_engine_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int TIMEOUT = 63
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [64*NUM_REQ-1:0]    req_message,
  input  logic [768*NUM_REQ-1:0]   req_keys,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [63:0]              rsp_data,
  output logic [ID_W-1:0]          rsp_id,
  output logic                     rsp_err,
  output logic                     eng_start,
  output logic [63:0]              eng_message,
  output logic [767:0]             eng_round_keys,
  input  logic                     eng_done,
  input  logic [63:0]              eng_result,
  output logic [1:0]               dbg_state,
  output logic [ID_W-1:0]          dbg_rr_ptr
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_BUSY   = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  // Reject configurations the id tag or the 6-bit watchdog cannot represent.
  if (NUM_REQ < 2 || NUM_REQ > 8 || ID_W != $clog2(NUM_REQ) ||
      TIMEOUT < 1 || TIMEOUT > 63) begin : g_bad_cfg
    $error("des_engine_arbiter: unsupported parameter set");
  end

  state_t          state;
  logic [ID_W-1:0] rr_ptr;
  logic            eng_start_q;
  logic            rsp_valid_q;
  logic [63:0]     rsp_data_q;
  logic [ID_W-1:0] rsp_id_q;
  logic [63:0]     msg_q;
  logic [767:0]    keys_q;

  logic [63:0]     msg_arr [NUM_REQ];
  logic [767:0]    key_arr [NUM_REQ];

  logic            grant_found;
  logic [ID_W-1:0] grant_idx;
  logic [ID_W-1:0] rr_next;
  logic [ID_W:0]   cand;

`ifdef DES_ARB_TIMEOUT_EN
  logic [5:0]      to_cnt;
  logic            rsp_err_q;
`endif

  // Split the flat requester buses into per-requester slices.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
    assign msg_arr[i] = req_message[i*64 +: 64];
    assign key_arr[i] = req_keys[i*768 +: 768];
  end

  // Round-robin search: first valid requester at or after rr_ptr, wrapping.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr} + (ID_W+1)'(k);
      if (cand >= (ID_W+1)'(NUM_REQ)) begin
        cand = cand - (ID_W+1)'(NUM_REQ);
      end
      if (!grant_found && req_valid[cand[ID_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[ID_W-1:0];
      end
    end
  end

  // Pointer advances to the requester after the one just served.
  assign rr_next = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;

  // Ready is one-hot on the granted requester, and only while idle.
  always_comb begin
    req_ready = '0;
    if (state == S_IDLE && grant_found) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  // Main sequencer: accept, launch, wait for the engine, hold the response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      rr_ptr      <= '0;
      eng_start_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_id_q    <= '0;
      msg_q       <= '0;
      keys_q      <= '0;
`ifdef DES_ARB_TIMEOUT_EN
      to_cnt      <= '0;
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      eng_start_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (grant_found) begin
            msg_q       <= msg_arr[grant_idx];
            keys_q      <= key_arr[grant_idx];
            rsp_id_q    <= grant_idx;
            rr_ptr      <= rr_next;
            eng_start_q <= 1'b1;
            state       <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
`ifdef DES_ARB_TIMEOUT_EN
          to_cnt <= '0;
`endif
          state <= S_BUSY;
        end
        S_BUSY: begin
          if (eng_done) begin
            rsp_data_q  <= eng_result;
            rsp_valid_q <= 1'b1;
`ifdef DES_ARB_TIMEOUT_EN
            rsp_err_q   <= 1'b0;
`endif
            state       <= S_RESP;
          end
`ifdef DES_ARB_TIMEOUT_EN
          // The current cycle is the TIMEOUT-th BUSY cycle: abort the job.
          else if (to_cnt == 6'(TIMEOUT - 1)) begin
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b1;
            rsp_valid_q <= 1'b1;
            state       <= S_RESP;
          end else begin
            to_cnt <= to_cnt + 6'd1;
          end
`endif
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign eng_start      = eng_start_q;
  assign eng_message    = msg_q;
  assign eng_round_keys = keys_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_data       = rsp_data_q;
  assign rsp_id         = rsp_id_q;
  assign dbg_state      = state;
  assign dbg_rr_ptr     = rr_ptr;

`ifdef DES_ARB_TIMEOUT_EN
  assign rsp_err = rsp_err_q;
`else
  assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_des_engine_arbiter.sv
// tb_des_engine_arbiter
//   Directed bench for des_engine_arbiter. The engine is played by the bench
//   itself: it drives eng_done/eng_result on chosen cycles with hand-picked
//   ciphertexts. Inputs change on the falling edge, outputs are read there.
module tb_des_engine_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int ST_IDLE = 0;
  localparam int ST_LAUNCH = 1;
  localparam int ST_BUSY = 2;
  localparam int ST_RESP = 3;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NUM_REQ-1:0]     req_valid;
  logic [NUM_REQ-1:0]     req_ready;
  logic [64*NUM_REQ-1:0]  req_message;
  logic [768*NUM_REQ-1:0] req_keys;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [63:0]            rsp_data;
  logic [ID_W-1:0]        rsp_id;
  logic                   rsp_err;
  logic                   eng_start;
  logic [63:0]            eng_message;
  logic [767:0]           eng_round_keys;
  logic                   eng_done;
  logic [63:0]            eng_result;
  logic [1:0]             dbg_state;
  logic [ID_W-1:0]        dbg_rr_ptr;

  int checks = 0;
  int errors = 0;
  int hs_count = 0;
  int hs_expected = 0;

  logic [65:0] exp_q[$];

  // Requester plaintexts; requester 2 carries the reference DES vector.
  logic [63:0] msg_tab [NUM_REQ] = '{
    64'h1111_2222_3333_4444,
    64'hA5A5_0F0F_C3C3_9696,
    64'h0123_4567_89AB_CDEF,
    64'hFEDC_BA98_7654_3210
  };
  // Ciphertexts the bench's engine returns for each requester's job.
  logic [63:0] res_tab [NUM_REQ] = '{
    64'h0000_0000_DEAD_BEEF,
    64'h1234_5678_9ABC_DEF0,
    64'h85E8_1354_0F0A_B405,
    64'hCAFE_F00D_0BAD_F00D
  };

  des_engine_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .TIMEOUT(63)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_message   (req_message),
    .req_keys      (req_keys),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_data      (rsp_data),
    .rsp_id        (rsp_id),
    .rsp_err       (rsp_err),
    .eng_start     (eng_start),
    .eng_message   (eng_message),
    .eng_round_keys(eng_round_keys),
    .eng_done      (eng_done),
    .eng_result    (eng_result),
    .dbg_state     (dbg_state),
    .dbg_rr_ptr    (dbg_rr_ptr)
  );

  // Clock and response-handshake counter.
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rsp_valid && rsp_ready) hs_count <= hs_count + 1;
  end

  function automatic logic [767:0] keys_of(input int i);
    logic [767:0] k;
    for (int j = 0; j < 12; j++) begin
      k[j*64 +: 64] = ~msg_tab[i] ^ 64'(j);
    end
    return k;
  endfunction

  task automatic check(input string tag, input logic [767:0] obs, input logic [767:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, req_ready, 0);
    check({tag, "_rsp_valid"}, rsp_valid, 0);
    check({tag, "_rsp_data"}, rsp_data, 0);
    check({tag, "_rsp_id"}, rsp_id, 0);
    check({tag, "_rsp_err"}, rsp_err, 0);
    check({tag, "_eng_start"}, eng_start, 0);
    check({tag, "_eng_message"}, eng_message, 0);
    check({tag, "_eng_keys"}, eng_round_keys, 0);
    check({tag, "_state"}, dbg_state, ST_IDLE);
    check({tag, "_rr_ptr"}, dbg_rr_ptr, 0);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One full job for requester id. Entered at a falling edge with the DUT idle
  // and req_valid already set; returns at a falling edge with the DUT idle.
  task automatic do_job(input int id, input int lat, input int hold, input bit drop);
    logic [65:0] exp;
    #1;
    check("idle_state", dbg_state, ST_IDLE);
    check("grant", req_ready, 4'b0001 << id);
    @(negedge clk);
    if (drop) req_valid[id] = 1'b0;
    check("launch_start", eng_start, 1);
    check("launch_state", dbg_state, ST_LAUNCH);
    check("launch_no_ready", req_ready, 0);
    check("eng_message", eng_message, msg_tab[id]);
    check("eng_keys", eng_round_keys, keys_of(id));
    check("rr_ptr_adv", dbg_rr_ptr, (id + 1) % NUM_REQ);
    @(negedge clk);
    check("busy_start_low", eng_start, 0);
    check("busy_state", dbg_state, ST_BUSY);
    repeat (lat) @(negedge clk);
    check("busy_no_rsp", rsp_valid, 0);
    eng_done   = 1'b1;
    eng_result = res_tab[id];
    exp_q.push_back({2'(id), res_tab[id]});
    hs_expected++;
    @(negedge clk);
    eng_done   = 1'b0;
    eng_result = 64'hFFFF_FFFF_FFFF_FFFF;
    exp = exp_q.pop_front();
    check("rsp_valid", rsp_valid, 1);
    check("rsp_err", rsp_err, 0);
    check("rsp_payload", {rsp_id, rsp_data}, exp);
    for (int k = 0; k < hold; k++) begin
      if (k == 0) begin
        eng_done   = 1'b1;
        eng_result = 64'h0BAD_0BAD_0BAD_0BAD;
      end
      @(negedge clk);
      eng_done = 1'b0;
      #1;
      check("hold_valid", rsp_valid, 1);
      check("hold_payload", {rsp_id, rsp_data}, exp);
      check("hold_no_ready", req_ready, 0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("back_idle", dbg_state, ST_IDLE);
    check("rsp_valid_clr", rsp_valid, 0);
  endtask

  // Accept one job and leave the DUT in LAUNCH with the request withdrawn.
  task automatic accept_only(input int id);
    req_valid = 4'b0001 << id;
    #1;
    check("acc_grant", req_ready, 4'b0001 << id);
    @(negedge clk);
    req_valid = '0;
    check("acc_launch", dbg_state, ST_LAUNCH);
  endtask

  initial begin
    int bad;
    rst         = 1'b1;
    req_valid   = '0;
    rsp_ready   = 1'b0;
    eng_done    = 1'b0;
    eng_result  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_message[i*64 +: 64]  = msg_tab[i];
      req_keys[i*768 +: 768]   = keys_of(i);
    end

    // Reset values.
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    // Requester 2 alone with the reference vector.
    req_valid = 4'b0100;
    do_job(2, 3, 0, 1'b1);
    check("solo_rr_ptr", dbg_rr_ptr, 3);

    // All requesters valid after reset: served 0,1,2,3,0; job 2 is back-pressured.
    pulse_reset();
    check("rr_after_reset", dbg_rr_ptr, 0);
    req_valid = 4'b1111;
    do_job(0, 0, 0, 1'b0);
    do_job(1, 5, 0, 1'b0);
    do_job(2, 1, 10, 1'b0);
    do_job(3, 2, 0, 1'b0);
    do_job(0, 4, 0, 1'b0);
    req_valid = '0;
    check("all_rr_ptr", dbg_rr_ptr, 1);

    // Stray done while idle produces nothing.
    eng_done   = 1'b1;
    eng_result = 64'h0BAD_CAFE_0BAD_CAFE;
    @(negedge clk);
    eng_done = 1'b0;
    check("stray_no_rsp", rsp_valid, 0);
    check("stray_idle", dbg_state, ST_IDLE);
    @(negedge clk);
    check("stray_no_rsp2", rsp_valid, 0);

    // Pointer at 1, only requester 3 valid: wraps to grant 3, pointer to 0.
    req_valid = 4'b1000;
    do_job(3, 2, 0, 1'b1);
    check("wrap_rr_ptr", dbg_rr_ptr, 0);

    // Reset in the middle of BUSY drops the job.
    accept_only(1);
    @(negedge clk);
    check("mid_busy", dbg_state, ST_BUSY);
    pulse_reset();
    check_reset_outputs("midrst");
    eng_done   = 1'b1;
    eng_result = 64'h7777_7777_7777_7777;
    @(negedge clk);
    eng_done = 1'b0;
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0) bad++;
    end
    check("midrst_no_rsp", bad, 0);
    req_valid = 4'b0010;
    do_job(1, 3, 0, 1'b1);
    check("midrst_rr_ptr", dbg_rr_ptr, 2);

`ifdef DES_ARB_TIMEOUT_EN
    // Engine never finishes: abort after 63 BUSY cycles.
    pulse_reset();
    accept_only(0);
    bad = 0;
    repeat (63) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0) bad++;
    end
    check("to_wait_no_rsp", bad, 0);
    check("to_still_busy", dbg_state, ST_BUSY);
    @(negedge clk);
    check("to_rsp_valid", rsp_valid, 1);
    check("to_rsp_err", rsp_err, 1);
    check("to_rsp_data", rsp_data, 0);
    check("to_rsp_id", rsp_id, 0);
    rsp_ready = 1'b1;
    hs_expected++;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("to_back_idle", dbg_state, ST_IDLE);

    // Done in the expiry cycle wins over the abort.
    accept_only(1);
    repeat (63) @(negedge clk);
    eng_done   = 1'b1;
    eng_result = res_tab[1];
    @(negedge clk);
    eng_done = 1'b0;
    check("to_edge_valid", rsp_valid, 1);
    check("to_edge_err", rsp_err, 0);
    check("to_edge_data", {rsp_id, rsp_data}, {2'd1, res_tab[1]});
    rsp_ready = 1'b1;
    hs_expected++;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("to_edge_idle", dbg_state, ST_IDLE);
`else
    // Engine never finishes: the block waits indefinitely.
    accept_only(0);
    rsp_ready = 1'b1;
    bad = 0;
    repeat (1000) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0) bad++;
    end
    rsp_ready = 1'b0;
    check("no_to_rsp_low", bad, 0);
    check("no_to_busy", dbg_state, ST_BUSY);
    check("no_to_err", rsp_err, 0);
    pulse_reset();
    check("no_to_recover", dbg_state, ST_IDLE);
`endif

    @(negedge clk);
    check("handshake_count", hs_count, hs_expected);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
